// File: rtl/ras_pkg.sv
// ----------------------------------------------------------------------------
// ras_pkg
// Shared types and helpers for the return-address-stack prediction checker.
//   PC_W_DEFAULT : default PC / target width
//   ras_entry_t  : one in-flight prediction {hit, pc} at the default width
//   count_w()    : width of an occupancy counter that can hold 0..depth
// ----------------------------------------------------------------------------
package ras_pkg;

  localparam int PC_W_DEFAULT = 32;

  typedef struct packed {
    logic                    hit;
    logic [PC_W_DEFAULT-1:0] pc;
  } ras_entry_t;

  // Occupancy must represent "depth" itself, hence one bit more than the index.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ras_pred_fifo.sv
// ----------------------------------------------------------------------------
// ras_pred_fifo
// DEPTH-entry circular buffer holding in-flight return predictions in program
// order. The head entry is always visible on rdata.
// Ports:
//   CLK, RESET      clock, asynchronous active-low reset
//   push, wdata     append an entry (ignored while full)
//   pop             retire the head entry (ignored while empty)
//   clear           drop every entry; wins over push and pop
//   rdata           current head entry (meaningless while count == 0)
//   count           number of valid entries, 0..DEPTH
//   full            count == DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ----------------------------------------------------------------------------
module ras_pred_fifo
  import ras_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clear,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; an entry is only ever
  // read after it has been written, so resetting it would just cost flops.
  always_ff @(posedge CLK) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ras_pred_check.sv
// ----------------------------------------------------------------------------
// ras_pred_check
// Verifies IF-stage `jr $ra` return predictions against the target resolved in
// EX. Predictions are queued in program order; each resolve retires the oldest
// one and, when it was wrong or absent, emits a one-cycle registered redirect.
// Ports:
//   CLK, RESET              clock, asynchronous active-low reset
//   pred_valid/hit/pc       prediction push from IF (pc ignored when !hit)
//   res_valid/res_target    resolve of the oldest in-flight jr from EX
//   flush                   squash everything younger than EX
//   full                    queue full, IF must stall jr fetch
//   mispredict/redirect_pc  registered one-cycle redirect to fetch
//   overflow                sticky: a push was attempted while full
//   correct_cnt/mispred_cnt saturating statistics (RAS_PRED_STATS_EN only)
// Build option: define RAS_PRED_STATS_EN to add the statistics counters.
// ----------------------------------------------------------------------------
module ras_pred_check
  import ras_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = PC_W_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            pred_valid,
  input  logic            pred_hit,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_target,
  input  logic            flush,
  output logic            full,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            overflow
`ifdef RAS_PRED_STATS_EN
  ,
  output logic [15:0]     correct_cnt,
  output logic [15:0]     mispred_cnt
`endif
);

  localparam int CW = count_w(DEPTH);

  typedef struct packed {
    logic            hit;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t        wr_entry;
  entry_t        head;
  logic [CW-1:0] fifo_count;
  logic          has_head;
  logic          push_req;
  logic          pop_req;
  logic          head_correct;
  logic          res_mis;

  assign wr_entry = '{hit: pred_hit, pc: pred_pc};
  assign has_head = (fifo_count != '0);

  // A flushed push never lands; full is not relieved by a same-cycle pop.
  assign push_req = pred_valid && !full && !flush;
  // With an empty queue the resolve is "unpredicted": no pop, just redirect.
  // This also keeps a same-cycle push into an empty queue from being compared.
  assign pop_req  = res_valid && has_head;

  assign head_correct = has_head && head.hit && (head.pc == res_target);
  assign res_mis      = res_valid && !head_correct;

  ras_pred_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push_req),
    .pop   (pop_req),
    .clear (flush),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (full)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      overflow    <= 1'b0;
    end else begin
      mispredict <= res_mis;
      if (res_mis)           redirect_pc <= res_target;
      if (pred_valid && full) overflow   <= 1'b1;
    end
  end

`ifdef RAS_PRED_STATS_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      correct_cnt <= '0;
      mispred_cnt <= '0;
    end else if (res_valid) begin
      if (head_correct && correct_cnt != 16'hFFFF) correct_cnt <= correct_cnt + 1'b1;
      if (!head_correct && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_pred_check.sv
// ----------------------------------------------------------------------------
// tb_ras_pred_check
// Directed scenarios followed by a randomized stream, all checked against a
// queue-based reference model of the prediction checker.
// Build option: define RAS_PRED_STATS_EN to also check the statistics ports.
// ----------------------------------------------------------------------------
module tb_ras_pred_check;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic            CLK;
  logic            RESET;
  logic            pred_valid;
  logic            pred_hit;
  logic [PC_W-1:0] pred_pc;
  logic            res_valid;
  logic [PC_W-1:0] res_target;
  logic            flush;
  logic            full;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic            overflow;
`ifdef RAS_PRED_STATS_EN
  logic [15:0]     correct_cnt;
  logic [15:0]     mispred_cnt;
`endif

  ras_pred_check #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .pred_valid  (pred_valid),
    .pred_hit    (pred_hit),
    .pred_pc     (pred_pc),
    .res_valid   (res_valid),
    .res_target  (res_target),
    .flush       (flush),
    .full        (full),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .overflow    (overflow)
`ifdef RAS_PRED_STATS_EN
    ,
    .correct_cnt (correct_cnt),
    .mispred_cnt (mispred_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state: in-flight predictions in program order.
  bit          m_hit[$];
  logic [31:0] m_pc[$];
  logic        e_mis;
  logic [31:0] e_redir;
  logic        e_ovf;
  int          e_ccnt;
  int          e_mcnt;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mispredict"},  32'(mispredict), 32'(e_mis));
    check({tag, ".redirect_pc"}, redirect_pc,     e_redir);
    check({tag, ".full"},        32'(full),       32'(m_hit.size() == DEPTH));
    check({tag, ".overflow"},    32'(overflow),   32'(e_ovf));
`ifdef RAS_PRED_STATS_EN
    check({tag, ".correct_cnt"}, 32'(correct_cnt), 32'(e_ccnt));
    check({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(e_mcnt));
`endif
  endtask

  task automatic model_reset();
    m_hit.delete();
    m_pc.delete();
    e_mis   = 1'b0;
    e_redir = '0;
    e_ovf   = 1'b0;
    e_ccnt  = 0;
    e_mcnt  = 0;
  endtask

  // One clock: drive inputs, advance the model by the rules, check after edge.
  task automatic cyc(input string tag, input bit pv, input bit ph, input logic [31:0] pp,
                     input bit rv, input logic [31:0] rt, input bit fl);
    bit was_full;
    bit ok;
    pred_valid = pv;
    pred_hit   = ph;
    pred_pc    = pp;
    res_valid  = rv;
    res_target = rt;
    flush      = fl;

    was_full = (m_hit.size() == DEPTH);
    ok       = 1'b0;
    if (rv) begin
      if (m_hit.size() > 0) begin
        ok = m_hit[0] && (m_pc[0] == rt);
        void'(m_hit.pop_front());
        void'(m_pc.pop_front());
      end
      e_mis = !ok;
      if (!ok) e_redir = rt;
      if (ok) e_ccnt = (e_ccnt < 65535) ? e_ccnt + 1 : e_ccnt;
      else    e_mcnt = (e_mcnt < 65535) ? e_mcnt + 1 : e_mcnt;
    end else begin
      e_mis = 1'b0;
    end
    if (pv && was_full) e_ovf = 1'b1;
    if (pv && !was_full && !fl) begin
      m_hit.push_back(ph);
      m_pc.push_back(pp);
    end
    if (fl) begin
      m_hit.delete();
      m_pc.delete();
    end

    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  logic [31:0] pc_set [4];

  initial begin
    pc_set[0] = 32'h0040_0100;
    pc_set[1] = 32'h0040_0200;
    pc_set[2] = 32'h0040_0300;
    pc_set[3] = 32'h0040_0400;

    RESET      = 1'b0;
    pred_valid = 1'b0;
    pred_hit   = 1'b0;
    pred_pc    = '0;
    res_valid  = 1'b0;
    res_target = '0;
    flush      = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge CLK);
    RESET = 1'b1;

    // Correct prediction: no redirect.
    cyc("push_a",  1, 1, 32'h0040_0100, 0, '0, 0);
    cyc("res_ok",  0, 0, '0, 1, 32'h0040_0100, 0);

    // Wrong target: one-cycle redirect, target held afterwards.
    cyc("push_b",  1, 1, 32'h0040_0100, 0, '0, 0);
    cyc("res_bad", 0, 0, '0, 1, 32'h0040_0200, 0);
    idle("bad_gone");

    // No RAS hit: redirect even though the pc field matches.
    cyc("push_nohit", 1, 0, 32'h0040_0300, 0, '0, 0);
    cyc("res_nohit",  0, 0, '0, 1, 32'h0040_0300, 0);
    // Unpredicted resolve on an empty queue; the queue must stay empty.
    cyc("res_empty",  0, 0, '0, 1, 32'h0040_0400, 0);
    cyc("push_c",     1, 1, 32'h0040_0500, 0, '0, 0);
    cyc("res_c",      0, 0, '0, 1, 32'h0040_0500, 0);

    // Push+pop on an empty queue: the pushed entry is not compared.
    cyc("pp_empty",   1, 1, 32'h0040_0550, 1, 32'h0040_0550, 0);
    cyc("pp_drain",   0, 0, '0, 1, 32'h0040_0550, 0);

    // Fill, overflow, then push+pop at full.
    for (int i = 0; i < DEPTH; i++)
      cyc($sformatf("fill%0d", i), 1, 1, 32'h0040_0600 + 32'(i * 4), 0, '0, 0);
    cyc("push_over", 1, 1, 32'h0040_0700, 0, '0, 0);
    cyc("pp_full",   1, 1, 32'h0040_0800, 1, 32'h0040_0600, 0);
    for (int i = 1; i < DEPTH; i++)
      cyc($sformatf("drain%0d", i), 0, 0, '0, 1, 32'h0040_0600 + 32'(i * 4), 0);
    cyc("drained", 0, 0, '0, 1, 32'h0040_0700, 0);

    // Flush with a correct same-cycle resolve and a discarded push.
    for (int i = 0; i < 3; i++)
      cyc($sformatf("pre_fl%0d", i), 1, 1, 32'h0040_0a00 + 32'(i * 4), 0, '0, 0);
    cyc("flush",    1, 1, 32'h0040_0b00, 1, 32'h0040_0a00, 1);
    cyc("post_fl",  0, 0, '0, 1, 32'h0040_0b00, 0);

    // Asynchronous reset with a mispredict on the outputs.
    cyc("rst_p0",  1, 1, 32'h0040_0c00, 0, '0, 0);
    cyc("rst_p1",  1, 1, 32'h0040_0c04, 0, '0, 0);
    cyc("rst_mis", 0, 0, '0, 1, 32'h0040_0d00, 0);
    #2;
    RESET = 1'b0;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    flush      = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    @(negedge CLK);
    RESET = 1'b1;
    // The surviving entry 0x400c04 must have been dropped by reset.
    cyc("rst_empty", 0, 0, '0, 1, 32'h0040_0c04, 0);

    // Randomized stream.
    for (int n = 0; n < 400; n++) begin
      bit          pv;
      bit          ph;
      bit          rv;
      bit          fl;
      logic [31:0] pp;
      logic [31:0] rt;
      pv = ($urandom_range(9) < 6);
      ph = ($urandom_range(7) != 0);
      pp = pc_set[$urandom_range(3)];
      rv = ($urandom_range(9) < 4);
      fl = ($urandom_range(15) == 0);
      if (m_pc.size() > 0 && $urandom_range(1) == 1) rt = m_pc[0];
      else                                          rt = pc_set[$urandom_range(3)];
      cyc($sformatf("rnd%0d", n), pv, ph, pp, rv, rt, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
